// File: rtl/rc4_prga_decryptor.sv
// RC4 keystream generator and decryptor: walks the permuted S RAM, swaps S[i]/S[j],
// XORs S[S[i]+S[j]] with each encrypted ROM byte and writes the plaintext RAM.
module rc4_prga_decryptor #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              finished,
    input  logic [7:0]        ram_out,
    output logic [7:0]        address,
    output logic [7:0]        ram_in,
    output logic              write_enable,
    output logic [MSG_AW-1:0] enc_address,
    input  logic [7:0]        enc_data,
    output logic [MSG_AW-1:0] dec_address,
    output logic [7:0]        dec_data,
    output logic              dec_write_enable,
    output logic [7:0]        iTap,
    output logic [7:0]        jTap,
    output logic [3:0]        stateTap
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        RD_SI  = 4'd1,
        GET_SI = 4'd2,
        RD_SJ  = 4'd3,
        GET_SJ = 4'd4,
        WR_SI  = 4'd5,
        WR_SJ  = 4'd6,
        RD_F   = 4'd7,
        GET_F  = 4'd8,
        WR_DEC = 4'd9,
        DONE   = 4'd10
    } state_e;

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    state_e            state_q, state_d;
    logic [7:0]        i_q, i_d;
    logic [7:0]        j_q, j_d;
    logic [MSG_AW-1:0] k_q, k_d;
    logic [7:0]        si_q, si_d;
    logic [7:0]        sj_q, sj_d;
    logic [7:0]        f_q, f_d;
    logic [7:0]        e_q, e_d;

    logic [7:0]        address_q, address_d;
    logic [7:0]        ram_in_q, ram_in_d;
    logic              write_enable_q, write_enable_d;
    logic [MSG_AW-1:0] enc_address_q, enc_address_d;
    logic [MSG_AW-1:0] dec_address_q, dec_address_d;
    logic [7:0]        dec_data_q, dec_data_d;
    logic              dec_write_enable_q, dec_write_enable_d;
    logic              finished_q, finished_d;

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        si_d    = si_q;
        sj_d    = sj_q;
        f_d     = f_q;
        e_d     = e_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    i_d     = 8'd1;
                    j_d     = 8'd0;
                    k_d     = '0;
                    state_d = RD_SI;
                end
            end
            RD_SI:  state_d = GET_SI;
            GET_SI: begin
                si_d    = ram_out;
                j_d     = j_q + ram_out;
                state_d = RD_SJ;
            end
            RD_SJ:  state_d = GET_SJ;
            GET_SJ: begin
                sj_d    = ram_out;
                state_d = WR_SI;
            end
            WR_SI:  state_d = WR_SJ;
            WR_SJ:  state_d = RD_F;
            RD_F:   state_d = GET_F;
            GET_F: begin
                f_d     = ram_out;
                e_d     = enc_data;
                state_d = WR_DEC;
            end
            WR_DEC: begin
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + MSG_AW'(1);
                    i_d     = i_q + 8'd1;
                    state_d = RD_SI;
                end
            end
            DONE: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet line up
    // with the cycle in which that state is current.
    always_comb begin
        address_d          = 8'd0;
        ram_in_d           = 8'd0;
        write_enable_d     = 1'b0;
        enc_address_d      = '0;
        dec_address_d      = '0;
        dec_data_d         = 8'd0;
        dec_write_enable_d = 1'b0;
        finished_d         = 1'b0;

        case (state_d)
            RD_SI: address_d = i_d;
            RD_SJ: address_d = j_d;
            WR_SI: begin
                address_d      = i_d;
                ram_in_d       = sj_d;
                write_enable_d = 1'b1;
            end
            WR_SJ: begin
                address_d      = j_d;
                ram_in_d       = si_d;
                write_enable_d = 1'b1;
            end
            RD_F: begin
                address_d     = si_d + sj_d;
                enc_address_d = k_d;
            end
            WR_DEC: begin
                dec_address_d      = k_d;
                dec_data_d         = f_d ^ e_d;
                dec_write_enable_d = 1'b1;
            end
            DONE:    finished_d = 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q            <= IDLE;
            i_q                <= 8'd0;
            j_q                <= 8'd0;
            k_q                <= '0;
            si_q               <= 8'd0;
            sj_q               <= 8'd0;
            f_q                <= 8'd0;
            e_q                <= 8'd0;
            address_q          <= 8'd0;
            ram_in_q           <= 8'd0;
            write_enable_q     <= 1'b0;
            enc_address_q      <= '0;
            dec_address_q      <= '0;
            dec_data_q         <= 8'd0;
            dec_write_enable_q <= 1'b0;
            finished_q         <= 1'b0;
        end else begin
            state_q            <= state_d;
            i_q                <= i_d;
            j_q                <= j_d;
            k_q                <= k_d;
            si_q               <= si_d;
            sj_q               <= sj_d;
            f_q                <= f_d;
            e_q                <= e_d;
            address_q          <= address_d;
            ram_in_q           <= ram_in_d;
            write_enable_q     <= write_enable_d;
            enc_address_q      <= enc_address_d;
            dec_address_q      <= dec_address_d;
            dec_data_q         <= dec_data_d;
            dec_write_enable_q <= dec_write_enable_d;
            finished_q         <= finished_d;
        end
    end

    assign address          = address_q;
    assign ram_in           = ram_in_q;
    assign write_enable     = write_enable_q;
    assign enc_address      = enc_address_q;
    assign dec_address      = dec_address_q;
    assign dec_data         = dec_data_q;
    assign dec_write_enable = dec_write_enable_q;
    assign finished         = finished_q;
    assign iTap             = i_q;
    assign jTap             = j_q;
    assign stateTap         = state_q;

endmodule

// File: tb/tb_rc4_prga_decryptor.sv
// Bench for rc4_prga_decryptor: behavioural S/ROM/RAM models plus a plain RC4 PRGA
// reference, driven through directed and randomized runs.
module tb_rc4_prga_decryptor;

    localparam int N   = 4;
    localparam int AW  = 2;
    localparam int LAT = 9 * N + 1;

    logic          clk;
    logic          reset;
    logic          start;
    logic          finished;
    logic [7:0]    ram_out;
    logic [7:0]    address;
    logic [7:0]    ram_in;
    logic          write_enable;
    logic [AW-1:0] enc_address;
    logic [7:0]    enc_data;
    logic [AW-1:0] dec_address;
    logic [7:0]    dec_data;
    logic          dec_write_enable;
    logic [7:0]    iTap;
    logic [7:0]    jTap;
    logic [3:0]    stateTap;

    rc4_prga_decryptor #(.MSG_LEN(N), .MSG_AW(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .finished         (finished),
        .ram_out          (ram_out),
        .address          (address),
        .ram_in           (ram_in),
        .write_enable     (write_enable),
        .enc_address      (enc_address),
        .enc_data         (enc_data),
        .dec_address      (dec_address),
        .dec_data         (dec_data),
        .dec_write_enable (dec_write_enable),
        .iTap             (iTap),
        .jTap             (jTap),
        .stateTap         (stateTap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memories: synchronous-read S RAM, encrypted ROM, plaintext RAM.
    logic [7:0] s_mem   [256];
    logic [7:0] s_init  [256];
    logic       s_load;
    logic [7:0] enc_rom [N];
    logic [7:0] dec_mem [N];

    always @(posedge clk) begin
        if (s_load) begin
            for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
        end else if (write_enable) begin
            s_mem[address] <= ram_in;
        end
        ram_out  <= s_mem[address];
        enc_data <= enc_rom[enc_address];
        if (dec_write_enable) dec_mem[dec_address] <= dec_data;
    end

    // Write monitor, sampled mid-cycle.
    logic [15:0] s_wr_q [$];
    logic [15:0] d_wr_q [$];
    int          overlap_cnt;
    int          strobe_in_rst;

    always @(negedge clk) begin
        if (!reset) begin
            if (write_enable || dec_write_enable) strobe_in_rst++;
        end else begin
            if (write_enable) s_wr_q.push_back({address, ram_in});
            if (dec_write_enable) d_wr_q.push_back({8'(dec_address), dec_data});
            if (write_enable && dec_write_enable) overlap_cnt++;
        end
    end

    // Reference model: textbook RC4 PRGA on an array copy of S.
    logic [7:0]  m_s [256];
    logic [15:0] exp_sw  [$];
    logic [15:0] exp_dec [$];

    task automatic model_run(input int n);
        int         i;
        int         j;
        logic [7:0] si;
        logic [7:0] sj;
        i = 0;
        j = 0;
        exp_sw.delete();
        exp_dec.delete();
        for (int k = 0; k < n; k++) begin
            i  = (i + 1) % 256;
            j  = (j + int'(m_s[i])) % 256;
            si = m_s[i];
            sj = m_s[j];
            exp_sw.push_back({8'(i), sj});
            exp_sw.push_back({8'(j), si});
            m_s[i] = sj;
            m_s[j] = si;
            exp_dec.push_back({8'(k), m_s[(int'(si) + int'(sj)) % 256] ^ enc_rom[k]});
        end
    endtask

    int compared;
    int mismatched;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_s(input bit ident);
        logic [7:0] t;
        int         r;
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        if (!ident) begin
            for (int x = 255; x > 0; x--) begin
                r         = int'($urandom_range(x, 0));
                t         = s_init[x];
                s_init[x] = s_init[r];
                s_init[r] = t;
            end
        end
        for (int x = 0; x < 256; x++) m_s[x] = s_init[x];
        s_load = 1'b1;
        tick();
        s_load = 1'b0;
    endtask

    task automatic fill_enc(input int mode);
        for (int k = 0; k < N; k++)
            enc_rom[k] = (mode == 0) ? 8'h00 : (mode == 1) ? 8'hFF : 8'($urandom);
    endtask

    task automatic compare_s_mem(input string tag);
        int diff;
        diff = 0;
        for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) diff++;
        check({tag, " s_ram_diff"}, diff, 0);
    endtask

    task automatic do_run(input string tag, input bit drop_mid, input bit hold_after);
        int cyc;
        int fcnt;
        bit seen;
        s_wr_q.delete();
        d_wr_q.delete();
        overlap_cnt = 0;
        model_run(N);
        start = 1'b1;
        cyc   = 0;
        seen  = 1'b0;
        while (!seen && cyc < 20 * LAT) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                check({tag, " first_address"}, address, 8'h01);
                check({tag, " first_iTap"}, iTap, 8'h01);
                check({tag, " first_jTap"}, jTap, 8'h00);
            end
            if (drop_mid && cyc == 12) start = 1'b0;
            if (drop_mid && cyc == 15) start = 1'b1;
            if (finished) seen = 1'b1;
        end
        check({tag, " finish_latency"}, cyc, LAT);
        check({tag, " s_write_count"}, s_wr_q.size(), 2 * N);
        check({tag, " dec_write_count"}, d_wr_q.size(), N);
        check({tag, " strobe_overlap"}, overlap_cnt, 0);
        for (int k = 0; k < 2 * N; k++) check({tag, " s_write"}, s_wr_q[k], exp_sw[k]);
        for (int k = 0; k < N; k++) begin
            check({tag, " dec_write"}, d_wr_q[k], exp_dec[k]);
            check({tag, " dec_ram"}, dec_mem[k], exp_dec[k][7:0]);
        end
        compare_s_mem(tag);
        if (hold_after) begin
            fcnt = 0;
            for (int c = 0; c < 20; c++) begin
                tick();
                if (finished) fcnt++;
            end
            check({tag, " finished_held"}, fcnt, 20);
            check({tag, " no_writes_in_done"}, s_wr_q.size() + d_wr_q.size(), 3 * N);
        end
        start = 1'b0;
        tick();
        check({tag, " finished_drop"}, finished, 1'b0);
        check({tag, " back_to_idle"}, stateTap, 4'd0);
    endtask

    initial begin
        int cyc;
        compared      = 0;
        mismatched    = 0;
        overlap_cnt   = 0;
        strobe_in_rst = 0;
        reset  = 1'b0;
        start  = 1'b0;
        s_load = 1'b0;
        fill_enc(0);
        repeat (3) tick();
        check("reset_outputs", {address, ram_in, write_enable, enc_address, dec_address, dec_data,
                                dec_write_enable, finished, iTap, jTap, stateTap}, 64'd0);
        check("reset_state", stateTap, 4'd0);
        reset = 1'b1;
        tick();

        // Identity S, zero ciphertext: keystream visible directly.
        load_s(1'b1);
        fill_enc(0);
        do_run("ident00", 1'b0, 1'b1);
        check("ident00 dec0", d_wr_q[0], 16'h0002);
        check("ident00 dec1", d_wr_q[1], 16'h0105);
        check("ident00 dec2", d_wr_q[2], 16'h0207);
        check("ident00 sw0", s_wr_q[0], 16'h0101);
        check("ident00 sw1", s_wr_q[1], 16'h0101);
        check("ident00 sw2", s_wr_q[2], 16'h0203);
        check("ident00 sw3", s_wr_q[3], 16'h0302);
        check("ident00 sw4", s_wr_q[4], 16'h0305);
        check("ident00 sw5", s_wr_q[5], 16'h0502);
        check("ident00 S2", s_mem[2], 8'h03);
        check("ident00 S3", s_mem[3], 8'h05);
        check("ident00 S5", s_mem[5], 8'h02);

        // Re-run continues on the already modified S.
        fill_enc(2);
        do_run("rerun", 1'b0, 1'b0);

        // Identity S, all-ones ciphertext; byte 0 exercises i==j.
        load_s(1'b1);
        fill_enc(1);
        do_run("identFF", 1'b0, 1'b0);
        check("identFF dec0", d_wr_q[0][7:0], 8'hFD);
        check("identFF dec1", d_wr_q[1][7:0], 8'hFA);
        check("identFF dec2", d_wr_q[2][7:0], 8'hF8);
        check("identFF ieqj0", s_wr_q[0], 16'h0101);
        check("identFF ieqj1", s_wr_q[1], 16'h0101);

        // Random permutation with start dropped for 3 cycles during byte 1.
        load_s(1'b0);
        fill_enc(2);
        do_run("start_drop", 1'b1, 1'b0);

        // Asynchronous reset during WR_SI of byte 2.
        load_s(1'b0);
        fill_enc(2);
        s_wr_q.delete();
        d_wr_q.delete();
        model_run(2);
        start = 1'b1;
        cyc   = 0;
        while (!(stateTap == 4'd5 && iTap == 8'd3) && cyc < 200) begin
            tick();
            cyc++;
        end
        check("abort reached_wr_si", cyc < 200, 1'b1);
        reset = 1'b0;
        #1;
        check("abort outputs_zero", {address, ram_in, write_enable, enc_address, dec_address, dec_data,
                                     dec_write_enable, finished, iTap, jTap, stateTap}, 64'd0);
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("abort strobes_in_reset", strobe_in_rst, 0);
        check("abort dec_count", d_wr_q.size(), 2);
        for (int k = 0; k < 2; k++) check("abort dec_ram", dec_mem[k], exp_dec[k][7:0]);
        compare_s_mem("abort");
        fill_enc(2);
        do_run("post_reset", 1'b0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            load_s(1'b0);
            fill_enc(2);
            do_run("random", 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
